// File: rtl/ils_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ils_decoder_pkg
// Shared types and helpers for the RV32 I/LOAD/STORE decoder.
//   cls_e   : record class (ALU_I, LOAD, STORE, ILLEGAL)
//   OPC_*   : the three recognised major opcodes
//   s1_t    : stage-1 payload (classified fields + raw 12-bit immediate)
//   rec_t   : decoded output record (fields + sign-extended immediate)
//   classify / extract / assemble : combinational decode helpers
// ----------------------------------------------------------------------------
package ils_decoder_pkg;

   typedef enum logic [1:0] {
      CLS_ALU_I   = 2'd0,
      CLS_LOAD    = 2'd1,
      CLS_STORE   = 2'd2,
      CLS_ILLEGAL = 2'd3
   } cls_e;

   localparam logic [6:0] OPC_ALU_I = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef struct packed {
      cls_e        cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
   } rec_t;

   // The immediate travels through stage 1 as its 12 raw bits, already
   // gathered from the I- or S-format positions; stage 2 sign-extends it.
   typedef struct packed {
      cls_e        cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [11:0] imm12;
   } s1_t;

   function automatic cls_e classify(input logic [31:0] instr);
      logic [6:0] f7;
      logic [2:0] f3;
      cls_e       c;
      f7 = instr[31:25];
      f3 = instr[14:12];
      c  = CLS_ILLEGAL;
      case (instr[6:0])
         OPC_ALU_I: begin
            c = CLS_ALU_I;
            // Shift-immediates reuse imm[11:5] as a function code.
            if (f3 == 3'd1 && f7 != 7'h00) c = CLS_ILLEGAL;
            if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) c = CLS_ILLEGAL;
         end
         OPC_LOAD:  c = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? CLS_ILLEGAL : CLS_LOAD;
         OPC_STORE: c = (f3 >= 3'd3) ? CLS_ILLEGAL : CLS_STORE;
         default:   c = CLS_ILLEGAL;
      endcase
      return c;
   endfunction

   function automatic s1_t extract(input logic [31:0] instr);
      s1_t s;
      s.cls    = classify(instr);
      // STORE has no destination; ALU_I/LOAD have no second source.
      s.rd     = (s.cls == CLS_STORE) ? 5'd0 : instr[11:7];
      s.rs1    = instr[19:15];
      s.rs2    = (s.cls == CLS_ALU_I || s.cls == CLS_LOAD) ? 5'd0 : instr[24:20];
      s.funct3 = instr[14:12];
      s.imm12  = (s.cls == CLS_STORE) ? {instr[31:25], instr[11:7]} : instr[31:20];
      return s;
   endfunction

   function automatic rec_t assemble(input s1_t s);
      rec_t r;
      r.cls    = s.cls;
      r.rd     = s.rd;
      r.rs1    = s.rs1;
      r.rs2    = s.rs2;
      r.funct3 = s.funct3;
      r.imm    = (s.cls == CLS_ILLEGAL) ? 32'd0 : {{20{s.imm12[11]}}, s.imm12};
      return r;
   endfunction

endpackage

// File: rtl/ils_decoder_pipe_stage.sv
// ----------------------------------------------------------------------------
// ils_pipe_stage
// One valid/ready register slice with a W-bit payload.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i    : upstream side
//   out_valid_o/out_ready_i/out_data_o : downstream side (registered)
//
// Handshake: a beat transfers on a side when valid && ready in the same
// cycle; valid never depends on ready, and a held beat keeps its data stable
// until it transfers. in_ready_o is combinational: the slice accepts when it
// is empty or when its current beat is leaving this cycle, so a full chain
// streams one beat per cycle with no bubbles.
// ----------------------------------------------------------------------------
module ils_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign in_ready_o  = !valid_q || out_ready_i;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_ready_o) begin
         valid_d = in_valid_i;
         // Data only loads on an accepted beat, so idle input never disturbs it.
         if (in_valid_i) data_d = in_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/ils_decoder.sv
// ----------------------------------------------------------------------------
// ils_decoder
// Two-stage pipelined decoder for RV32 ALU-immediate, LOAD and STORE words,
// with saturating per-class counters of completed records.
//   clk, reset (async, active-low)
//   in_valid/in_ready/instr           : instruction input handshake
//   out_valid/out_ready               : record output handshake
//   cls, rd, rs1, rs2, funct3, imm    : decoded record (registered)
//   cnt_alu/load/store/illegal        : completed-record counts, CNT_W wide
// Stage 1 extracts fields and classifies; stage 2 builds the sign-extended
// immediate and is the output register.
// ----------------------------------------------------------------------------
module ils_decoder
   import ils_decoder_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       cls,
   output logic [4:0]       rd,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [2:0]       funct3,
   output logic [31:0]      imm,
   output logic [CNT_W-1:0] cnt_alu,
   output logic [CNT_W-1:0] cnt_load,
   output logic [CNT_W-1:0] cnt_store,
   output logic [CNT_W-1:0] cnt_illegal
);

   localparam int S1_W  = $bits(s1_t);
   localparam int REC_W = $bits(rec_t);

   s1_t              s1_in;
   logic [S1_W-1:0]  s1_data;
   logic             s1_valid;
   logic             s2_ready;
   rec_t             s2_in;
   logic [REC_W-1:0] s2_data;
   rec_t             rec;

   assign s1_in = extract(instr);

   ils_pipe_stage #(.W(S1_W)) u_s1 (
      .clk_i       (clk),
      .rst_ni      (reset),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (s1_in),
      .out_valid_o (s1_valid),
      .out_ready_i (s2_ready),
      .out_data_o  (s1_data)
   );

   assign s2_in = assemble(s1_t'(s1_data));

   ils_pipe_stage #(.W(REC_W)) u_s2 (
      .clk_i       (clk),
      .rst_ni      (reset),
      .in_valid_i  (s1_valid),
      .in_ready_o  (s2_ready),
      .in_data_i   (s2_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (s2_data)
   );

   assign rec    = rec_t'(s2_data);
   assign cls    = rec.cls;
   assign rd     = rec.rd;
   assign rs1    = rec.rs1;
   assign rs2    = rec.rs2;
   assign funct3 = rec.funct3;
   assign imm    = rec.imm;

   // Counters indexed by class encoding; one bumps per output handshake.
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   always_comb begin
      for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
      if (out_valid && out_ready && cnt_q[rec.cls] != {CNT_W{1'b1}})
         cnt_d[rec.cls] = cnt_q[rec.cls] + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign cnt_alu     = cnt_q[CLS_ALU_I];
   assign cnt_load    = cnt_q[CLS_LOAD];
   assign cnt_store   = cnt_q[CLS_STORE];
   assign cnt_illegal = cnt_q[CLS_ILLEGAL];

endmodule

// File: doc/ils_decoder.md
ILS_DECODER -- requirements
Module: ils_decoder

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of each per-class statistics counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  instr holds a word offered for decode.
REQ-005 in_ready  output  1  decoder accepts instr this cycle.
REQ-006 instr  input  32  RV32 instruction word.
REQ-007 out_valid  output  1  decoded record present on outputs.
REQ-008 out_ready  input  1  consumer accepts record this cycle.
REQ-009 cls  output  2  record class: 0 ALU_I (opcode 0010011), 1 LOAD (0000011), 2 STORE (0100011), 3 ILLEGAL.
REQ-010 rd, rs1, rs2  output  5 each  register fields; rd forced 0 for STORE, rs2 forced 0 for ALU_I/LOAD.
REQ-011 funct3  output  3  instr[14:12].
REQ-012 imm  output  32  sign-extended immediate: I-format {instr[31:20]} for ALU_I/LOAD, S-format {instr[31:25],instr[11:7]} for STORE, 0 for ILLEGAL.
REQ-013 cnt_alu, cnt_load, cnt_store, cnt_illegal  output  CNT_W each  completed-record counts per class.

Function
REQ-014 Decoding SHALL be a 2-stage registered pipeline (S1: field extract + classification; S2: immediate assembly + output register); latency 2 cycles from input handshake to out_valid with no backpressure.
REQ-015 Input handshake = in_valid && in_ready; output handshake = out_valid && out_ready.
REQ-016 Each stage SHALL advance when empty or when its downstream is consuming this cycle; in_ready = !S1_valid || S1 advances, combinationally.
REQ-017 Under out_ready=0, the decoder SHALL hold at most 2 records, keep all outputs stable, and deassert in_ready once both stages are full.
REQ-018 Records SHALL leave in acceptance order; no drop, no duplication.
REQ-019 ILLEGAL SHALL be reported for: opcode outside the three classes; ALU_I funct3=1 with instr[31:25]!=0; ALU_I funct3=5 with instr[31:25] not in {0x00,0x20}; LOAD funct3 in {3,6,7}; STORE funct3 >= 3.
REQ-020 On each output handshake exactly one counter SHALL increment, selected by cls; counters saturate at all-ones.
REQ-021 Simultaneous input and output handshake with both stages full SHALL shift the pipeline with zero bubbles (throughput 1/cycle).
REQ-022 instr value is ignored when in_valid=0; no state change results.

Reset
REQ-023 Asserting reset (low) SHALL asynchronously clear both stage valids, out_valid=0, all counters=0, and all data outputs to 0.
REQ-024 Reset mid-stream SHALL discard in-flight records without counting them; in_ready=1 on the first cycle after deassertion.

Structure
REQ-025 A shared package SHALL hold the cls enumeration, the three opcode constants, and the decoded-record struct (cls, rd, rs1, rs2, funct3, imm).
REQ-026 One sub-module, ils_pipe_stage (valid/ready register slice, parameterised payload), SHALL implement both stages.

Verification
REQ-027 instr=0xFFF10093 (addi x1,x2,-1) with out_ready=1 -> 2 cycles later cls=0, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF; cnt_alu=1.
REQ-028 instr=0xFFC32203 (lw x4,-4(x6)) -> cls=1, rd=4, rs1=6, funct3=2, imm=0xFFFFFFFC; then 0x0051A423 (sw x5,8(x3)) next cycle -> cls=2, rs1=3, rs2=5, rd=0, imm=0x00000008, back-to-back out_valid.
REQ-029 instr=0x02009093 (slli, imm[11:5]=1) -> cls=3, imm=0, cnt_illegal=1; 0x00000013 -> cls=0, rd=0, imm=0.
REQ-030 3 valid words with out_ready=0 for 5 cycles -> first 2 accepted, in_ready=0, outputs stable; on out_ready=1 all 3 emerge in order.
REQ-031 Counter preloaded by 2^CNT_W-1 ALU_I records plus 1 more -> cnt_alu stays 0xFFFF (CNT_W=16).
REQ-032 reset low while 2 records in flight -> out_valid=0 immediately, counters 0, no records emerge after release.
